// File: rtl/game_pkg.sv
// game_pkg: shared state codes, sprite sizes and screen limits for the game datapath.
package game_pkg;
    localparam logic [1:0] GAME_INITIAL = 2'b00;
    localparam logic [1:0] GAME_RUNNING = 2'b01;
    localparam logic [1:0] GAME_OVER    = 2'b10;
    localparam logic [1:0] GAME_SUCCESS = 2'b11;
    localparam int MARIO_W       = 34;
    localparam int MARIO_H       = 36;
    localparam int BARREL_ROLL_W = 32;
    localparam int BARREL_ROLL_H = 24;
    localparam int BARREL_FALL_W = 42;
    localparam int BARREL_FALL_H = 24;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    typedef enum logic [2:0] {S_INIT, S_RUN, S_HIT, S_OVER, S_SUCC} seq_state_t;
    function automatic logic [1:0] state_code(input seq_state_t s);
        return (s == S_RUN || s == S_HIT) ? GAME_RUNNING :
               (s == S_OVER) ? GAME_OVER :
               (s == S_SUCC) ? GAME_SUCCESS : GAME_INITIAL;
    endfunction
endpackage

// File: rtl/game_sequencer_aabb.sv
// aabb_overlap: strict axis-aligned box overlap, widened to 11 bits so edge sums never wrap.
module aabb_overlap (
    input  logic [9:0] ax,
    input  logic [8:0] ay,
    input  logic [9:0] aw,
    input  logic [8:0] ah,
    input  logic [9:0] bx,
    input  logic [8:0] by,
    input  logic [9:0] bw,
    input  logic [8:0] bh,
    output logic       overlap
);
    assign overlap = (11'(ax) < 11'(bx) + 11'(bw)) && (11'(bx) < 11'(ax) + 11'(aw)) &&
                     (11'(ay) < 11'(by) + 11'(bh)) && (11'(by) < 11'(ay) + 11'(ah));
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round flow, hit/goal detection, lives and barrel spawn scheduling.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int MARIO_W      = game_pkg::MARIO_W,
    parameter int MARIO_H      = game_pkg::MARIO_H,
    parameter int GOAL_X0      = 250,
    parameter int GOAL_X1      = 330,
    parameter int GOAL_Y       = 60,
    parameter int SPAWN_PERIOD = 120,
    parameter int HIT_FRAMES   = 60,
    parameter int RESTART_HOLD = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [4:0] key,
    input  logic [9:0] mario_x,
    input  logic [8:0] mario_y,
    input  logic [9:0] barrel_x,
    input  logic [8:0] barrel_y,
    input  logic [9:0] barrel_w,
    input  logic [8:0] barrel_h,
    input  logic       barrel_active,
    output logic [1:0] state,
    output logic       freeze,
    output logic       barrel_spawn,
    output logic [1:0] lives,
    output logic       hit_flag
);
    localparam int SW = $clog2(SPAWN_PERIOD);
    localparam int HW = $clog2(HIT_FRAMES);
    localparam int RW = $clog2(RESTART_HOLD + 1);
    seq_state_t cur, nxt;
    logic [1:0]    lives_nxt;
    logic [SW-1:0] spawn_cnt, spawn_nxt;
    logic [HW-1:0] hit_cnt, hit_nxt;
    logic [RW-1:0] hold_cnt, hold_nxt;
    logic box_hit, overlap, goal, spawn_due, spawn_fire, hold_full;
    aabb_overlap u_mario_barrel (
        .ax(mario_x), .ay(mario_y), .aw(10'(MARIO_W)), .ah(9'(MARIO_H)),
        .bx(barrel_x), .by(barrel_y), .bw(barrel_w), .bh(barrel_h),
        .overlap(box_hit)
    );
    assign overlap    = box_hit && barrel_active;
    assign goal       = mario_y <= 9'(GOAL_Y) && mario_x >= 10'(GOAL_X0) && mario_x < 10'(GOAL_X1);
    assign spawn_due  = spawn_cnt == SW'(SPAWN_PERIOD - 1);
    assign spawn_fire = tick && cur == S_RUN && spawn_due && !barrel_active;
    assign hold_full  = hold_cnt == RW'(RESTART_HOLD);
    always_comb begin
        nxt       = cur;
        lives_nxt = lives;
        spawn_nxt = spawn_cnt;
        hit_nxt   = hit_cnt;
        hold_nxt  = hold_cnt;
        if (tick) begin
            case (cur)
                S_INIT: if (key != '0) begin
                    nxt       = S_RUN;
                    lives_nxt = 2'(LIVES_INIT);
                    spawn_nxt = '0;
                end
                S_RUN: begin
                    // a still-active barrel defers the spawn with the counter parked at its limit
                    spawn_nxt = spawn_fire ? '0 : spawn_due ? spawn_cnt : spawn_cnt + 1'b1;
                    if (overlap) begin
                        lives_nxt = (lives == '0) ? lives : lives - 2'd1;
                        nxt       = (lives_nxt == '0) ? S_OVER : S_HIT;
                        hit_nxt   = '0;
                        hold_nxt  = '0;
                    end else if (goal) begin
                        nxt      = S_SUCC;
                        hold_nxt = '0;
                    end
                end
                S_HIT: begin
                    hit_nxt = hit_cnt + 1'b1;
                    nxt     = (hit_cnt == HW'(HIT_FRAMES - 1)) ? S_RUN : S_HIT;
                end
                default: begin
                    hold_nxt = hold_full ? hold_cnt : hold_cnt + 1'b1;
                    nxt      = (key != '0 && hold_full) ? S_INIT : cur;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= S_INIT;
            lives        <= 2'(LIVES_INIT);
            spawn_cnt    <= '0;
            hit_cnt      <= '0;
            hold_cnt     <= '0;
            hit_flag     <= 1'b0;
            barrel_spawn <= 1'b0;
        end else begin
            cur          <= nxt;
            lives        <= lives_nxt;
            spawn_cnt    <= spawn_nxt;
            hit_cnt      <= hit_nxt;
            hold_cnt     <= hold_nxt;
            hit_flag     <= tick ? overlap : hit_flag;
            barrel_spawn <= spawn_fire;
        end
    end
    assign state  = state_code(cur);
    assign freeze = cur == S_HIT;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed test-plan scenarios plus randomized play against a behavioural model.
module tb_game_sequencer;
    localparam int L_INIT = 3, MW = 34, MH = 36, GX0 = 250, GX1 = 330, GY = 60;
    localparam int PERIOD = 120, FRAMES = 60, HOLD = 30;
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, barrel_active = 1'b0;
    logic [4:0] key = '0;
    logic [9:0] mario_x = '0, barrel_x = '0, barrel_w = '0;
    logic [8:0] mario_y = '0, barrel_y = '0, barrel_h = '0;
    logic [1:0] state, lives;
    logic freeze, barrel_spawn, hit_flag;
    int n_vec = 0, n_err = 0;
    int e_state, e_lives, e_left, e_since, e_hold, e_spawn, e_hit;
    bit m_ov, m_goal;
    always #5 clk = ~clk;
    game_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .key(key),
        .mario_x(mario_x), .mario_y(mario_y),
        .barrel_x(barrel_x), .barrel_y(barrel_y), .barrel_w(barrel_w), .barrel_h(barrel_h),
        .barrel_active(barrel_active),
        .state(state), .freeze(freeze), .barrel_spawn(barrel_spawn), .lives(lives), .hit_flag(hit_flag)
    );
    task automatic cmp(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask
    // model: e_state is the visible code, e_left the freeze ticks still owed, counters run unbounded
    always @(posedge clk) begin
        if (rst) begin
            e_state = 0; e_lives = L_INIT; e_left = 0; e_since = 0; e_hold = 0; e_spawn = 0; e_hit = 0;
        end else begin
            e_spawn = 0;
            if (tick) begin
                m_ov = barrel_active && int'(mario_x) < int'(barrel_x) + int'(barrel_w)
                       && int'(barrel_x) < int'(mario_x) + MW
                       && int'(mario_y) < int'(barrel_y) + int'(barrel_h)
                       && int'(barrel_y) < int'(mario_y) + MH;
                m_goal = int'(mario_y) <= GY && int'(mario_x) >= GX0 && int'(mario_x) < GX1;
                e_hit = m_ov;
                if (e_state == 0) begin
                    if (key != 0) begin e_state = 1; e_lives = L_INIT; e_since = 0; end
                end else if (e_state == 1) begin
                    if (e_left > 0) e_left--;
                    else begin
                        if (e_since >= PERIOD - 1 && !barrel_active) begin e_spawn = 1; e_since = 0; end
                        else e_since++;
                        if (m_ov) begin
                            e_lives--;
                            if (e_lives == 0) begin e_state = 2; e_hold = 0; end
                            else e_left = FRAMES;
                        end else if (m_goal) begin e_state = 3; e_hold = 0; end
                    end
                end else begin
                    if (key != 0 && e_hold >= HOLD) e_state = 0;
                    e_hold++;
                end
            end
        end
    end
    always @(negedge clk) begin
        cmp("state", state, e_state);
        cmp("freeze", freeze, e_left > 0);
        cmp("barrel_spawn", barrel_spawn, e_spawn);
        cmp("lives", lives, e_lives);
        cmp("hit_flag", hit_flag, e_hit);
    end
    task automatic step(input bit t, input logic [4:0] k);
        tick = t; key = k;
        @(posedge clk); #2;
    endtask
    task automatic pos(input int mx, my, bx, by, bw, bh, input bit act);
        mario_x = 10'(mx); mario_y = 9'(my);
        barrel_x = 10'(bx); barrel_y = 9'(by); barrel_w = 10'(bw); barrel_h = 9'(bh);
        barrel_active = act;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 5'h00);
    endtask
    initial begin
        int pulses;
        pos(100, 300, 500, 400, 32, 24, 1'b0);
        step(1'b0, 5'h00); step(1'b0, 5'h00);
        rst = 1'b0;
        cmp("rst_state", state, 0); cmp("rst_lives", lives, 3);
        cmp("rst_freeze", freeze, 0); cmp("rst_hit", hit_flag, 0);
        ticks(5);
        cmp("idle_state", state, 0);
        step(1'b1, 5'h01);
        cmp("start_state", state, 1);
        pos(100, 200, 120, 210, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("hit1_flag", hit_flag, 1); cmp("hit1_lives", lives, 2); cmp("hit1_freeze", freeze, 1);
        pos(100, 300, 500, 400, 32, 24, 1'b0);
        ticks(FRAMES - 1);
        cmp("hit1_freeze_end", freeze, 1);
        ticks(1);
        cmp("hit1_resume_freeze", freeze, 0); cmp("hit1_resume_state", state, 1);
        pos(100, 200, 120, 210, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("hit2_lives", lives, 1);
        pos(100, 300, 500, 400, 32, 24, 1'b0);
        ticks(FRAMES);
        pos(100, 200, 120, 210, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("hit3_lives", lives, 0); cmp("hit3_state", state, 2);
        pos(100, 300, 500, 400, 32, 24, 1'b0);
        ticks(10);
        step(1'b1, 5'h02);
        cmp("early_key_state", state, 2);
        ticks(HOLD - 11);
        step(1'b1, 5'h02);
        cmp("restart_state", state, 0);
        step(1'b1, 5'h01);
        cmp("rerun_lives", lives, 3);
        pos(280, 50, 500, 400, 32, 24, 1'b0);
        step(1'b1, 5'h00);
        cmp("goal_state", state, 3);
        ticks(HOLD);
        step(1'b1, 5'h04);
        cmp("succ_restart", state, 0);
        step(1'b1, 5'h04);
        pos(280, 50, 280, 50, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("prio_state", state, 1); cmp("prio_freeze", freeze, 1); cmp("prio_lives", lives, 2);
        pos(100, 300, 500, 400, 32, 24, 1'b0);
        ticks(FRAMES);
        rst = 1'b1; step(1'b0, 5'h00); rst = 1'b0;
        step(1'b1, 5'h01);
        pulses = 0;
        for (int i = 1; i < PERIOD; i++) begin step(1'b1, 5'h00); pulses += barrel_spawn; end
        cmp("spawn_early", pulses, 0);
        step(1'b1, 5'h00);
        cmp("spawn_pulse", barrel_spawn, 1);
        step(1'b0, 5'h00);
        cmp("spawn_width", barrel_spawn, 0);
        barrel_active = 1'b1;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin step(1'b1, 5'h00); pulses += barrel_spawn; end
        cmp("spawn_deferred", pulses, 0);
        barrel_active = 1'b0;
        step(1'b1, 5'h00);
        cmp("spawn_retry", barrel_spawn, 1);
        pos(100, 200, 134, 200, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("edge_right", hit_flag, 0);
        pos(100, 200, 68, 200, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("edge_left", hit_flag, 0);
        pos(100, 200, 100, 236, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("edge_below", hit_flag, 0);
        pos(100, 200, 100, 176, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("edge_above", hit_flag, 0); cmp("edge_lives", lives, 3);
        pos(100, 200, 133, 200, 32, 24, 1'b1);
        step(1'b1, 5'h00);
        cmp("edge_in_hit", hit_flag, 1); cmp("edge_in_freeze", freeze, 1);
        pos(100, 300, 500, 400, 32, 24, 1'b0);
        ticks(20);
        rst = 1'b1; step(1'b0, 5'h00);
        cmp("midhit_state", state, 0); cmp("midhit_freeze", freeze, 0);
        cmp("midhit_lives", lives, 3); cmp("midhit_hit", hit_flag, 0); cmp("midhit_spawn", barrel_spawn, 0);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(999) == 0);
            if ($urandom_range(3) == 0)
                pos($urandom_range(340, 200), $urandom_range(120, 40), $urandom_range(400, 150),
                    $urandom_range(160, 20), $urandom_range(1) ? 32 : 42, 24, $urandom_range(2) == 0);
            step($urandom_range(1), ($urandom_range(5) == 0) ? 5'($urandom_range(31, 1)) : 5'h00);
        end
        rst = 1'b0;
        step(1'b0, 5'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
